// File: rtl/adder_pkg.sv
// Shared definitions for the carry-lookahead adder family: group lookahead
// carry function and stage-count helper.
package adder_pkg;

    localparam int MAX_GROUP = 32;

    typedef logic [MAX_GROUP-1:0] grp_vec_t;
    typedef logic [MAX_GROUP:0]   grp_carry_t;

    function automatic int calc_nstage(input int width, input int group);
        return width / group;
    endfunction

    // Two-level lookahead: c[i+1] = OR_j (g[j] & p[j+1..i]) | (p[0..i] & cin).
    // Unused upper p/g bits must be zero; callers truncate to GROUP+1 carries.
    function automatic grp_carry_t cla_group_carries(input grp_vec_t p,
                                                     input grp_vec_t g,
                                                     input logic     cin);
        grp_carry_t c;
        logic       term;
        c    = {(MAX_GROUP+1){1'b0}};
        c[0] = cin;
        for (int i = 0; i < MAX_GROUP; i++) begin
            term = cin;
            for (int j = 0; j <= i; j++) begin
                term = term & p[j];
            end
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_group.sv
// One combinational lookahead group: propagate/generate, carries, sum bits,
// plus the carry into the group MSB for signed-overflow detection.
module cla_group
    import adder_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [GROUP-1:0] p_s;
    logic [GROUP-1:0] g_s;
    logic [GROUP:0]   c_s;

    assign p_s  = a ^ b;
    assign g_s  = a & b;
    assign c_s  = (GROUP+1)'(cla_group_carries(grp_vec_t'(p_s), grp_vec_t'(g_s), cin));
    assign sum  = p_s ^ c_s[GROUP-1:0];
    assign cout = c_s[GROUP];
    assign cmsb = c_s[GROUP-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per
// stage, registered inter-group carry, valid/ready streaming with global stall.
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    if (GROUP < 1 || GROUP > MAX_GROUP || WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_bad_cfg
        $fatal(1, "pipelined_cla_adder: WIDTH must be a non-zero multiple of GROUP");
    end

    localparam int NSTAGE = calc_nstage(WIDTH, GROUP);
    localparam logic [WIDTH-1:0] GMASK = WIDTH'({GROUP{1'b1}});

    logic             en_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             c0_s;

    // Stage registers; a_r/b_r carry the not-yet-consumed operand bits,
    // s_r accumulates the finished low-order sum bits.
    logic             v_r   [NSTAGE];
    logic [WIDTH-1:0] a_r   [NSTAGE];
    logic [WIDTH-1:0] b_r   [NSTAGE];
    logic [WIDTH-1:0] s_r   [NSTAGE];
    logic             c_r   [NSTAGE];
    logic             ovf_r;

    logic [WIDTH-1:0] src_a_s   [NSTAGE];
    logic [WIDTH-1:0] src_b_s   [NSTAGE];
    logic [WIDTH-1:0] src_s_s   [NSTAGE];
    logic             src_c_s   [NSTAGE];
    logic [GROUP-1:0] grp_sum_s [NSTAGE];
    logic             grp_co_s  [NSTAGE];
    logic             grp_cm_s  [NSTAGE];
    logic [WIDTH-1:0] nxt_s_s   [NSTAGE];

    // Subtraction as a + ~b + (1 - cin); cin doubles as borrow-in.
    assign b_eff_s = sub ? ~b : b;
    assign c0_s    = cin ^ sub;
    assign en_s    = ~v_r[NSTAGE-1] | out_ready;
    assign in_ready = en_s;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign src_a_s[k] = a;
            assign src_b_s[k] = b_eff_s;
            assign src_c_s[k] = c0_s;
            assign src_s_s[k] = {WIDTH{1'b0}};
        end else begin : g_next
            assign src_a_s[k] = a_r[k-1];
            assign src_b_s[k] = b_r[k-1];
            assign src_c_s[k] = c_r[k-1];
            assign src_s_s[k] = s_r[k-1];
        end

        cla_group #(
            .GROUP (GROUP)
        ) u_grp (
            .a    (src_a_s[k][k*GROUP +: GROUP]),
            .b    (src_b_s[k][k*GROUP +: GROUP]),
            .cin  (src_c_s[k]),
            .sum  (grp_sum_s[k]),
            .cout (grp_co_s[k]),
            .cmsb (grp_cm_s[k])
        );

        assign nxt_s_s[k] = (src_s_s[k] & ~(GMASK << (k*GROUP)))
                          | (WIDTH'(grp_sum_s[k]) << (k*GROUP));
    end

    // Pipeline advance: all stages shift together when en_s is high, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTAGE; k++) begin
                v_r[k] <= 1'b0;
                c_r[k] <= 1'b0;
                s_r[k] <= {WIDTH{1'b0}};
            end
            ovf_r <= 1'b0;
        end else if (en_s) begin
            v_r[0] <= in_valid;
            for (int k = 1; k < NSTAGE; k++) begin
                v_r[k] <= v_r[k-1];
            end
            for (int k = 0; k < NSTAGE; k++) begin
                a_r[k] <= src_a_s[k];
                b_r[k] <= src_b_s[k];
                c_r[k] <= grp_co_s[k];
                s_r[k] <= nxt_s_s[k];
            end
            ovf_r <= grp_co_s[NSTAGE-1] ^ grp_cm_s[NSTAGE-1];
        end
    end

    assign out_valid = v_r[NSTAGE-1];
    assign sum       = s_r[NSTAGE-1];
    assign cout      = c_r[NSTAGE-1];
    assign ovf       = ovf_r;

endmodule
